// File: rtl/d_seq_detector.sv
// Serial 1011 pattern detector (overlapping) fed by the upstream flop's o_q.
// Emits a registered one-cycle match pulse and keeps a saturating match count.
// i_enable freezes the stream; i_cnt_clr clears only the counter.
module d_seq_detector #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_clr,
   input  logic                 i_enable,
   input  logic                 i_d,
   input  logic                 i_cnt_clr,
   output logic                 o_match,
   output logic [CNT_WIDTH-1:0] o_match_cnt,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_1    = 2'd1,
      S_10   = 2'd2,
      S_101  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic                 match_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

   // Next state, match pulse and counter update; counter clear beats increment
   always_comb begin
      state_nxt = state;
      match_nxt = 1'b0;
      cnt_nxt   = cnt;
      if (i_enable) begin
         case (state)
            S_IDLE: state_nxt = i_d ? S_1   : S_IDLE;
            S_1:    state_nxt = i_d ? S_1   : S_10;
            S_10:   state_nxt = i_d ? S_101 : S_IDLE;
            S_101: begin
               // trailing 1 of a match is the first 1 of the next pattern
               state_nxt = i_d ? S_1 : S_10;
               match_nxt = i_d;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
      if (match_nxt && (cnt != {CNT_WIDTH{1'b1}}))
         cnt_nxt = cnt + CNT_WIDTH'(1);
      if (i_cnt_clr)
         cnt_nxt = '0;
   end

   // State, pulse and counter registers with asynchronous clear
   always_ff @(posedge i_clk or posedge i_clr) begin
      if (i_clr) begin
         state   <= S_IDLE;
         o_match <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         o_match <= match_nxt;
         cnt     <= cnt_nxt;
      end
   end

   assign o_match_cnt = cnt;
   assign o_state     = state;

endmodule

// File: tb/tb_d_seq_detector.sv
// Scoreboarded bench for d_seq_detector: a bit-history reference model pushes
// the expected outputs per edge; a monitor pops and compares after each edge.
// Two instances (8-bit and 2-bit counter) share the same stimulus.
module tb_d_seq_detector;

   logic       clk = 1'b0;
   logic       i_clr = 1'b1;
   logic       i_enable = 1'b0;
   logic       i_d = 1'b0;
   logic       i_cnt_clr = 1'b0;
   logic       m8, m2;
   logic [7:0] c8;
   logic [1:0] c2;
   logic [1:0] s8, s2;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int st;
      int m;
      int c8;
      int c2;
   } exp_t;
   exp_t sb[$];

   // reference model state: enabled bits seen since reset, and counts
   bit hist[$];
   int mc8 = 0;
   int mc2 = 0;
   bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   d_seq_detector #(.CNT_WIDTH(8)) dut8 (
      .i_clk(clk), .i_clr(i_clr), .i_enable(i_enable), .i_d(i_d),
      .i_cnt_clr(i_cnt_clr), .o_match(m8), .o_match_cnt(c8), .o_state(s8)
   );

   d_seq_detector #(.CNT_WIDTH(2)) dut2 (
      .i_clk(clk), .i_clr(i_clr), .i_enable(i_enable), .i_d(i_d),
      .i_cnt_clr(i_cnt_clr), .o_match(m2), .o_match_cnt(c2), .o_state(s2)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // length of the longest history suffix that is a proper prefix of 1011
   function automatic int prefix_len();
      for (int l = 3; l >= 1; l--) begin
         if (hist.size() >= l) begin
            bit ok = 1'b1;
            for (int i = 0; i < l; i++)
               if (hist[hist.size() - l + i] != pat[i]) ok = 1'b0;
            if (ok) return l;
         end
      end
      return 0;
   endfunction

   // apply inputs for the next rising edge and queue the expected result
   task automatic drive(bit clr, bit en, bit d, bit cc);
      exp_t e;
      bit   hit;
      @(negedge clk);
      i_clr = clr; i_enable = en; i_d = d; i_cnt_clr = cc;
      hit = 1'b0;
      if (clr) begin
         hist.delete();
         mc8 = 0;
         mc2 = 0;
      end else begin
         if (en) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] == 1'b1 && hist[1] == 1'b0 &&
                hist[2] == 1'b1 && hist[3] == 1'b1)
               hit = 1'b1;
         end
         if (hit) begin
            mc8 = (mc8 < 255) ? mc8 + 1 : 255;
            mc2 = (mc2 < 3)   ? mc2 + 1 : 3;
         end
         if (cc) begin
            mc8 = 0;
            mc2 = 0;
         end
      end
      e.st = prefix_len();
      e.m  = int'(hit);
      e.c8 = mc8;
      e.c2 = mc2;
      sb.push_back(e);
   endtask

   task automatic feed(string bits, bit en = 1'b1);
      for (int i = 0; i < bits.len(); i++)
         drive(1'b0, en, bits[i] == "1", 1'b0);
   endtask

   // monitor: every edge the DUT presents a fresh result
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("state8", int'(s8), e.st);
            check("match8", int'(m8), e.m);
            check("cnt8",   int'(c8), e.c8);
            check("state2", int'(s2), e.st);
            check("match2", int'(m2), e.m);
            check("cnt2",   int'(c2), e.c2);
         end
      end
   end

   initial begin
      // reset values before any clock edge
      #1;
      check("rst_state", int'(s8), 0);
      check("rst_match", int'(m8), 0);
      check("rst_cnt",   int'(c8), 0);
      check("rst_cnt2",  int'(c2), 0);
      // reset held with i_d toggling
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);   // release; first real bit is 1
      feed("011011");                  // basic + overlap: 1011011
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      feed("100101011");               // non-match and recovery
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      feed("101");                     // enable gating
      feed("000", 1'b0);
      feed("1");
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      feed("1011011011011011");        // five matches, 2-bit count saturates
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1);   // clear on a match edge
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      feed("101");
      // asynchronous reset between edges
      @(posedge clk);
      #3;
      i_clr = 1'b1;
      #1;
      check("async_state", int'(s8), 0);
      check("async_match", int'(m8), 0);
      check("async_cnt",   int'(c8), 0);
      hist.delete();
      mc8 = 0;
      mc2 = 0;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      feed("1");                       // lone 1 after release: no match
      // randomized traffic
      for (int i = 0; i < 600; i++)
         drive($urandom_range(99) < 1, $urandom_range(99) < 80,
               1'($urandom), $urandom_range(99) < 4);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
